// File: rtl/tri_assemble.sv
// tri_assemble -- turns a stream of projected float vertices into screen-space
// triangles for the rasterizer.
//
// Each x/y pair is scaled by 2^SCALE_LOG2, truncated toward zero, saturated
// to +/-4095, then mapped to screen pixels. The screen origin is top-left and
// y points down. Every three consecutive vertices make one triangle, which is
// presented on a valid/ready handshake.
//
// Optional feature: define CULL_DEGENERATE_EN to drop zero-area triangles when
// they complete. The default build forwards every triangle.
//
// Ports:
//   clk_in        system clock
//   rst_in        asynchronous active-high reset
//   coor_in       float vertex, coor_in[1]=x, coor_in[0]=y
//   valid_in      single-cycle pulse, vertex present
//   ready_out     a vertex can be accepted this cycle
//   tri_x_out     triangle x pixels, index 0 = first received vertex
//   tri_y_out     triangle y pixels
//   tri_valid_out triangle held on tri_x_out/tri_y_out
//   tri_ready_in  rasterizer accepts the triangle
//   overflow_out  sticky, a vertex was dropped at the input
module tri_assemble #(
   parameter int H_RES      = 1280,
   parameter int V_RES      = 720,
   parameter int SCALE_LOG2 = 9
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic [1:0][31:0]  coor_in,
   input  logic              valid_in,
   output logic              ready_out,
   output logic [2:0][10:0]  tri_x_out,
   output logic [2:0][9:0]   tri_y_out,
   output logic              tri_valid_out,
   input  logic              tri_ready_in,
   output logic              overflow_out
);

   localparam logic signed [15:0] X_CTR   = 16'(H_RES / 2);
   localparam logic signed [15:0] Y_CTR   = 16'(V_RES / 2);
   localparam logic signed [15:0] X_MAX   = 16'(H_RES - 1);
   localparam logic signed [15:0] Y_MAX   = 16'(V_RES - 1);
   localparam logic signed [9:0]  SCALE_S = 10'(SCALE_LOG2);

   // Float -> signed 13-bit fixed point, trunc toward zero, saturating at 4095.
   function automatic logic signed [12:0] float_to_fix(input logic [31:0] f);
      logic [7:0]         e;
      logic [23:0]        mant;
      logic signed [9:0]  sexp;
      logic [4:0]         sh;
      logic [11:0]        mag;
      e    = f[30:23];
      mant = {1'b1, f[22:0]};
      // Unbiased exponent after multiplying by 2^SCALE_LOG2.
      sexp = $signed({2'b00, e}) - 10'sd127 + SCALE_S;
      sh   = 5'd23 - sexp[4:0];
      if (e == 8'd0) begin
         mag = 12'd0;                        // zero and denormals
      end else if (e == 8'hff) begin
         mag = 12'd4095;                     // Inf and NaN
      end else if (sexp < 10'sd0) begin
         mag = 12'd0;
      end else if (sexp > 10'sd11) begin
         mag = 12'd4095;
      end else begin
         mag = 12'(mant >> sh);
      end
      if (f[31]) begin
         return -$signed({1'b0, mag});
      end else begin
         return $signed({1'b0, mag});
      end
   endfunction

   // Clamp a signed screen position into [0, H_RES-1].
   function automatic logic [10:0] clamp_x(input logic signed [15:0] v);
      if (v < 16'sd0) begin
         return 11'd0;
      end else if (v > X_MAX) begin
         return X_MAX[10:0];
      end else begin
         return v[10:0];
      end
   endfunction

   // Clamp a signed screen position into [0, V_RES-1].
   function automatic logic [9:0] clamp_y(input logic signed [15:0] v);
      if (v < 16'sd0) begin
         return 10'd0;
      end else if (v > Y_MAX) begin
         return Y_MAX[9:0];
      end else begin
         return v[9:0];
      end
   endfunction

   logic                    s1_valid_r;
   logic signed [12:0]      s1_x_r;
   logic signed [12:0]      s1_y_r;
   logic                    s2_valid_r;
   logic [10:0]             s2_px_r;
   logic [9:0]              s2_py_r;
   logic [2:0][10:0]        slot_x_r;
   logic [2:0][9:0]         slot_y_r;
   logic [1:0]              count_r;       // 0..2 stored, 3 = complete triangle waiting
   logic                    overflow_r;

   logic [2:0]              occ_s;
   logic                    accept_s;
   logic                    drop_s;
   logic                    arrive_third_s;
   logic                    held_full_s;
   logic                    complete_s;
   logic                    slot_free_s;
   logic                    degenerate_s;
   logic                    move_s;
   logic [2:0][10:0]        cand_x_s;
   logic [2:0][9:0]         cand_y_s;

   assign occ_s = {1'b0, count_r} + {2'b00, s1_valid_r} + {2'b00, s2_valid_r};
   // Holding the output means the pipeline cannot take more than 3 vertices.
   assign ready_out      = !((occ_s >= 3'd3) && tri_valid_out && !tri_ready_in);
   assign accept_s       = valid_in && ready_out;
   assign drop_s         = valid_in && !ready_out;
   assign arrive_third_s = s2_valid_r && (count_r == 2'd2);
   assign held_full_s    = (count_r == 2'd3);
   assign complete_s     = arrive_third_s || held_full_s;
   assign slot_free_s    = !tri_valid_out || tri_ready_in;
   assign move_s         = complete_s && !degenerate_s && slot_free_s;
   assign overflow_out   = overflow_r;

   // Triangle candidate: either the held full buffer or two stored plus the arriving vertex.
   always_comb begin
      cand_x_s = slot_x_r;
      cand_y_s = slot_y_r;
      if (held_full_s) begin
         cand_x_s = slot_x_r;
         cand_y_s = slot_y_r;
      end else begin
         cand_x_s = {s2_px_r, slot_x_r[1], slot_x_r[0]};
         cand_y_s = {s2_py_r, slot_y_r[1], slot_y_r[0]};
      end
   end

`ifdef CULL_DEGENERATE_EN
   // Sign-extend a 12-bit difference to the 24-bit area width.
   function automatic logic signed [23:0] sx24(input logic signed [11:0] v);
      return {{12{v[11]}}, v};
   endfunction

   logic signed [11:0] dx1_s, dy1_s, dx2_s, dy2_s;
   logic signed [23:0] area2_s;

   assign dx1_s   = $signed({1'b0, cand_x_s[1]}) - $signed({1'b0, cand_x_s[0]});
   assign dx2_s   = $signed({1'b0, cand_x_s[2]}) - $signed({1'b0, cand_x_s[0]});
   assign dy1_s   = $signed({2'b00, cand_y_s[1]}) - $signed({2'b00, cand_y_s[0]});
   assign dy2_s   = $signed({2'b00, cand_y_s[2]}) - $signed({2'b00, cand_y_s[0]});
   assign area2_s = sx24(dx1_s) * sx24(dy2_s) - sx24(dx2_s) * sx24(dy1_s);
   // Only a freshly completed triangle is tested; a held one already passed.
   assign degenerate_s = arrive_third_s && (area2_s == 24'sd0);
`else
   assign degenerate_s = 1'b0;
`endif

   // Conversion pipeline: stage 1 float->fixed, stage 2 screen map and clamp.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         s1_valid_r <= 1'b0;
         s1_x_r     <= 13'sd0;
         s1_y_r     <= 13'sd0;
         s2_valid_r <= 1'b0;
         s2_px_r    <= 11'd0;
         s2_py_r    <= 10'd0;
      end else begin
         s1_valid_r <= accept_s;
         if (accept_s) begin
            s1_x_r <= float_to_fix(coor_in[1]);
            s1_y_r <= float_to_fix(coor_in[0]);
         end else begin
            s1_x_r <= s1_x_r;
            s1_y_r <= s1_y_r;
         end
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            s2_px_r <= clamp_x(X_CTR + {{3{s1_x_r[12]}}, s1_x_r});
            s2_py_r <= clamp_y(Y_CTR - {{3{s1_y_r[12]}}, s1_y_r});
         end else begin
            s2_px_r <= s2_px_r;
            s2_py_r <= s2_py_r;
         end
      end
   end

   // Assembly buffer: store vertices, hand off, hold, or cull completed triangles.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         count_r  <= 2'd0;
         slot_x_r <= '0;
         slot_y_r <= '0;
      end else if (arrive_third_s && degenerate_s) begin
         count_r <= 2'd0;
      end else if (move_s) begin
         if (held_full_s && s2_valid_r) begin
            // A vertex leaving the pipeline alongside the move starts the next triangle.
            slot_x_r[0] <= s2_px_r;
            slot_y_r[0] <= s2_py_r;
            count_r     <= 2'd1;
         end else begin
            count_r <= 2'd0;
         end
      end else if (arrive_third_s) begin
         slot_x_r[2] <= s2_px_r;
         slot_y_r[2] <= s2_py_r;
         count_r     <= 2'd3;
      end else if (s2_valid_r && !held_full_s) begin
         slot_x_r[count_r] <= s2_px_r;
         slot_y_r[count_r] <= s2_py_r;
         count_r           <= count_r + 2'd1;
      end else begin
         count_r <= count_r;
      end
   end

   // Output slot: load on move (back-to-back reload keeps valid high), clear on handshake.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         tri_valid_out <= 1'b0;
         tri_x_out     <= '0;
         tri_y_out     <= '0;
      end else if (move_s) begin
         tri_valid_out <= 1'b1;
         tri_x_out     <= cand_x_s;
         tri_y_out     <= cand_y_s;
      end else if (tri_valid_out && tri_ready_in) begin
         tri_valid_out <= 1'b0;
      end else begin
         tri_valid_out <= tri_valid_out;
      end
   end

   // Sticky overflow flag, set when a vertex arrives while not ready.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         overflow_r <= 1'b0;
      end else if (drop_s) begin
         overflow_r <= 1'b1;
      end else begin
         overflow_r <= overflow_r;
      end
   end

endmodule

// File: tb/tb_tri_assemble.sv
// Directed bench for tri_assemble. Expected triangles go into a scoreboard
// queue as the third vertex is driven. They are popped and compared whenever
// a handshake is seen on the negative clock edge.
module tb_tri_assemble;

   typedef struct packed {
      logic [2:0][10:0] x;
      logic [2:0][9:0]  y;
   } tri_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [1:0][31:0] coor = '0;
   logic             valid = 1'b0;
   logic             ready;
   logic [2:0][10:0] tri_x;
   logic [2:0][9:0]  tri_y;
   logic             tri_valid;
   logic             tri_ready = 1'b0;
   logic             overflow;

   tri_t             sb[$];
   tri_t             acc;
   int               nacc = 0;
   int               n_tests = 0;
   int               n_fail = 0;
   int               n_pops = 0;

   tri_assemble dut (
      .clk_in        (clk),
      .rst_in        (rst),
      .coor_in       (coor),
      .valid_in      (valid),
      .ready_out     (ready),
      .tri_x_out     (tri_x),
      .tri_y_out     (tri_y),
      .tri_valid_out (tri_valid),
      .tri_ready_in  (tri_ready),
      .overflow_out  (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Float bits for n/512 (exact for |n| < 2^24).
   function automatic logic [31:0] enc(input int n);
      int          mag;
      int          p;
      logic [31:0] m;
      if (n == 0) return 32'h0;
      mag = (n < 0) ? -n : n;
      p = 0;
      for (int i = 0; i < 31; i++) if ((mag >> i) != 0) p = i;
      m = 32'(mag) << (23 - p);
      return {(n < 0) ? 1'b1 : 1'b0, 8'(127 + p - 9), m[22:0]};
   endfunction

   function automatic int clampi(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   // Monitor the handshake at the upcoming edge, then advance one cycle.
   task automatic step();
      tri_t e;
      if (tri_valid && tri_ready) begin
         check("tri_expected", {63'd0, sb.size() != 0}, 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("tri_data", {1'b0, tri_x, tri_y}, {1'b0, e});
         end
         n_pops++;
      end
      @(negedge clk);
   endtask

   // Record an expected vertex; on the third one push the triangle unless culled.
   task automatic expect_vtx(input int px, input int py);
      int area;
      acc.x[nacc] = 11'(px);
      acc.y[nacc] = 10'(py);
      nacc++;
      if (nacc == 3) begin
         nacc = 0;
         area = (int'(acc.x[1]) - int'(acc.x[0])) * (int'(acc.y[2]) - int'(acc.y[0]))
              - (int'(acc.x[2]) - int'(acc.x[0])) * (int'(acc.y[1]) - int'(acc.y[0]));
`ifdef CULL_DEGENERATE_EN
         if (area != 0) sb.push_back(acc);
`else
         sb.push_back(acc);
`endif
      end
   endtask

   task automatic send_raw(input logic [31:0] fx, input logic [31:0] fy, input int px, input int py);
      coor  = {fx, fy};
      valid = 1'b1;
      if (ready) expect_vtx(px, py);
      step();
      valid = 1'b0;
   endtask

   task automatic send_n(input int nx, input int ny);
      send_raw(enc(nx), enc(ny), clampi(640 + nx, 0, 1279), clampi(360 - ny, 0, 719));
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && sb.size() != 0; i++) step();
      check("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      int p0;
      int bx[6] = '{10, 100, -30, 200, -200, 5};
      int by[6] = '{20, -50, 40, 100, 150, -300};

      // Reset state
      #1;
      check("rst_valid", {63'd0, tri_valid}, 64'd0);
      check("rst_ready", {63'd0, ready}, 64'd1);
      check("rst_ovf", {63'd0, overflow}, 64'd0);
      check("rst_tri", {1'b0, tri_x, tri_y}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      tri_ready = 1'b1;

      // Centre vertex triangle and its 3-cycle latency
      send_raw(32'h00000000, 32'h00000000, 640, 360);
      send_raw(32'h3f800000, 32'h00000000, 1152, 360);
      send_raw(32'h00000000, 32'h3f800000, 640, 0);
      check("lat_c1", {63'd0, tri_valid}, 64'd0);
      step();
      check("lat_c2", {63'd0, tri_valid}, 64'd0);
      step();
      check("lat_c3", {63'd0, tri_valid}, 64'd1);
      check("centre_x", {31'd0, tri_x}, {31'd0, 11'd640, 11'd1152, 11'd640});
      check("centre_y", {34'd0, tri_y}, {34'd0, 10'd0, 10'd360, 10'd360});
      step();
      check("centre_fall", {63'd0, tri_valid}, 64'd0);

      // Clamp and special values
      send_raw(32'hc0000000, 32'h00000000, 0, 360);
      send_raw(32'h7f800000, 32'h000116c2, 1279, 360);
      send_raw(32'h3e800000, 32'h3f800000, 768, 0);
      drain();

      // Backpressure, overflow and bubble-free release
      tri_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check("bp_ready_hi", {63'd0, ready}, 64'd1);
         send_n(bx[i], by[i]);
      end
      check("bp_ready_lo", {63'd0, ready}, 64'd0);
      check("bp_valid", {63'd0, tri_valid}, 64'd1);
      coor  = {enc(7), enc(7)};
      valid = 1'b1;
      step();
      valid = 1'b0;
      check("bp_ovf", {63'd0, overflow}, 64'd1);
      for (int i = 0; i < 3; i++) begin
         check("bp_hold", {1'b0, tri_x, tri_y}, {1'b0, sb[0]});
         step();
      end
      check("bp_q2", 64'(sb.size()), 64'd2);
      p0 = n_pops;
      tri_ready = 1'b1;
      step();
      check("bp_nobubble", {63'd0, tri_valid}, 64'd1);
      step();
      check("bp_two_pops", 64'(n_pops - p0), 64'd2);
      check("bp_done", {63'd0, tri_valid}, 64'd0);

      // Reset mid-triangle
      send_n(50, 60);
      send_n(-70, 80);
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      nacc = 0;
      check("mrst_valid", {63'd0, tri_valid}, 64'd0);
      check("mrst_ovf", {63'd0, overflow}, 64'd0);
      step();
      step();
      step();
      p0 = n_pops;
      send_n(300, -100);
      send_n(-300, 200);
      send_n(123, 321);
      drain();
      check("mrst_pops", 64'(n_pops - p0), 64'd1);

      // Streaming, 30 vertices back-to-back
      p0 = n_pops;
      for (int i = 0; i < 30; i++) begin
         check("st_ready", {63'd0, ready}, 64'd1);
         send_n(int'($urandom_range(0, 1400)) - 700, int'($urandom_range(0, 1400)) - 700);
      end
      drain();
      check("st_pops", 64'(n_pops - p0), 64'd10);
      check("st_ovf", {63'd0, overflow}, 64'd0);

      // Collinear triangle, then a normal one
      tri_ready = 1'b0;
      send_raw(32'h00000000, 32'h00000000, 640, 360);
      send_raw(32'h3f000000, 32'h00000000, 896, 360);
      send_raw(32'h3f800000, 32'h00000000, 1152, 360);
      step();
      step();
      step();
`ifdef CULL_DEGENERATE_EN
      check("cull_valid", {63'd0, tri_valid}, 64'd0);
`else
      check("cull_valid", {63'd0, tri_valid}, 64'd1);
`endif
      tri_ready = 1'b1;
      send_n(10, 10);
      send_n(200, 10);
      send_n(10, 200);
      drain();
      check("cull_ovf", {63'd0, overflow}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
